sd_cmd_seq: RTL and testbench
=============================

Name: sd_cmd_seq

Overview:
- SD-card SPI-mode command sequencer that sits directly upstream of the SPI byte engine.
- It takes a command index and a 32-bit argument from the host/CPU side, drives chip select, and frames the 6-byte command. It feeds that frame one byte at a time through the engine's wr/busy handshake.
- It then polls for the R1 response and reports R1 or a timeout. It also supports single-byte reads for trailing R3/R7/data bytes while CS is held low.

Parameters:
- POLL_MAX, 8: maximum number of 0xFF poll bytes sent while waiting for R1 before declaring timeout. Legal range 1..255.
- POST_BYTES, 1: number of 0xFF bytes clocked with cs_n high after CS release. These provide the 8 extra SCLKs the card requires.

Ports:
- clk  in  1  system clock, shared with the SPI engine
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a command; accepted only while ready=1
- cmd  in  6  command index (CMD0..CMD63)
- arg  in  32  command argument, MSB sent first
- keep_cs  in  1  sampled with start; 1 = leave cs_n low after R1
- rd_byte  in  1  read one extra byte (send 0xFF); accepted only when ready=1 and cs_n=0
- release  in  1  deassert CS and send POST_BYTES; accepted only when ready=1 and cs_n=0
- ready  out  1  idle, able to accept start/rd_byte/release
- done  out  1  one-cycle pulse at the end of every accepted operation
- r1  out  8  last R1 response (0xFF on timeout)
- rx_byte  out  8  byte returned by the last rd_byte
- timeout  out  1  1 if the last command saw no R1 within POLL_MAX polls; cleared by next start
- cs_n  out  1  card chip select, active low
- spi_wr  out  1  one-cycle write strobe to the SPI engine
- spi_tx  out  8  byte to the SPI engine
- spi_rx  in  8  SPI engine received byte
- spi_busy  in  1  SPI engine busy

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, ready=1, done=0, r1=8'hFF, rx_byte=8'hFF, timeout=0, cs_n=1, spi_wr=0, spi_tx=8'hFF.
  - Reset mid-operation aborts immediately with cs_n=1.
  - The SPI engine has no reset and may still be mid-byte. The first issue after reset waits for spi_busy=0.
- Byte primitive (ISSUE/WAIT):
  - ISSUE: when spi_busy=0, drive spi_tx and pulse spi_wr for exactly one cycle, then go to WAIT.
  - WAIT: ignore spi_busy in the first WAIT cycle, because the engine raises busy one clock after wr. Remain in WAIT while spi_busy=1. On spi_busy=0, spi_rx is valid and is captured that cycle.
  - Never assert spi_wr while spi_busy=1.
- States: IDLE, PRE, FRAME, POLL, RD, POST.
- IDLE:
  - If start: latch cmd, arg, keep_cs; clear timeout; set cs_n=0, ready=0; go to PRE.
  - Else if rd_byte and cs_n=0: go to RD.
  - Else if release and cs_n=0: set cs_n=1; go to POST.
  - Priority is start > rd_byte > release. rd_byte/release with cs_n=1 are ignored; no done pulse.
- PRE: one 0xFF byte with cs_n low, then FRAME.
- FRAME: 6 bytes in order:
  - {2'b01,cmd}
  - arg[31:24], arg[23:16], arg[15:8], arg[7:0]
  - {crc7,1'b1}
  - Byte counter is 3 bits, 0..5.
- POLL: send 0xFF and capture spi_rx.
  - If spi_rx[7]=0: r1<=spi_rx.
  - Else if the poll count reaches POLL_MAX: r1<=8'hFF, timeout<=1.
  - On either end condition:
    - If keep_cs=1 and not timeout: done pulse, then IDLE with cs_n=0.
    - Otherwise: set cs_n=1 and go to POST.
- RD: one 0xFF byte. rx_byte<=spi_rx, done pulse, then IDLE with cs_n still 0.
- POST: POST_BYTES bytes of 0xFF with cs_n=1, then done pulse and IDLE.
- done and the return to ready=1 occur in the same cycle. The next start may be accepted on the following cycle.
- Inputs other than start/rd_byte/release are don't-care while ready=0. start asserted while ready=0 is dropped, not queued.
- Latency in bytes, start to done: 1+6+n+POST_BYTES, where n = poll bytes used (1..POLL_MAX). With keep_cs=1 and no timeout: 1+6+n.

Optional Feature:
- Macro: SD_CMD_CRC7_EN.
- Defined: crc7 is computed over the 40 bits {2'b01,cmd,arg}, polynomial x^7+x^3+1, initial value 0, MSB first. It is computed combinationally from the latched fields, so no extra cycles.
- Undefined: crc7 is a constant table.
  - cmd=0: 7'h4A, giving byte 0x95.
  - cmd=8: 7'h43, giving byte 0x87.
  - All other cmd: 7'h7F, giving byte 0xFF (CRC is ignored by the card once in SPI mode).

Test Plan:
- CMD0, arg=0, keep_cs=0; model returns 0xFF,0x01 -> spi_tx sequence FF,40,00,00,00,00,95,FF,FF,FF. r1=0x01, timeout=0, cs_n high during the final FF, single done pulse.
- CMD8, arg=0x1AA, keep_cs=1; R1=0x01 on first poll -> frame 48,00,00,01,AA,87, cs_n stays 0. Four rd_byte ops return 00,00,01,AA in rx_byte, then release -> one FF with cs_n=1, done.
- CMD17, arg=0, SD_CMD_CRC7_EN defined -> CRC byte 0x55. With the macro undefined -> 0xFF.
- Model never answers (all 0xFF), POLL_MAX=8 -> exactly 8 poll bytes, r1=0xFF, timeout=1, cs_n=1, POST byte sent, done.
- Simultaneous start and rd_byte while idle with cs_n=0 -> start wins, PRE begins. start pulsed mid-command -> ignored, only one command frame sent.
- rst_n=0 during FRAME byte 3 while the engine is busy -> next cycle cs_n=1, ready=1, r1=FF. The following start issues no spi_wr until spi_busy=0. Bench also checks spi_wr is never high while spi_busy=1.

Source files
------------

// File: rtl/sd_cmd_seq.sv
// SD-card SPI-mode command sequencer: frames a 6-byte command, polls for R1, and handles trailing reads and CS release.
// Optional build macro SD_CMD_CRC7_EN computes a real CRC7; without it a constant table covers CMD0/CMD8.
module sd_cmd_seq #(
  parameter int unsigned POLL_MAX   = 8,
  parameter int unsigned POST_BYTES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [5:0]  i_cmd,
  input  logic [31:0] i_arg,
  input  logic        i_keep_cs,
  input  logic        i_rd_byte,
  input  logic        i_release,
  output logic        o_ready,
  output logic        o_done,
  output logic [7:0]  o_r1,
  output logic [7:0]  o_rx_byte,
  output logic        o_timeout,
  output logic        o_cs_n,
  output logic        o_spi_wr,
  output logic [7:0]  o_spi_tx,
  input  logic [7:0]  i_spi_rx,
  input  logic        i_spi_busy
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_FRAME, S_POLL, S_RD, S_POST} state_t;

  localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);
  localparam logic [7:0] POST_LAST = 8'(POST_BYTES - 1);

  state_t      r_state, w_state_nxt;
  logic        r_wait, r_first;
  logic [7:0]  r_cnt;
  logic [5:0]  r_cmd;
  logic [31:0] r_arg;
  logic        r_keep;
  logic [7:0]  r_r1, r_rx;
  logic        r_timeout, r_cs_n, r_done;

  logic        w_spi_wr, w_byte_done, w_poll_hit;
  logic [7:0]  w_frame_byte;
  logic [6:0]  w_crc7;

`ifdef SD_CMD_CRC7_EN
  function automatic logic [6:0] crc7_calc(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  assign w_crc7 = crc7_calc({2'b01, r_cmd, r_arg});
`else
  always_comb begin
    case (r_cmd)
      6'd0:    w_crc7 = 7'h4A;
      6'd8:    w_crc7 = 7'h43;
      default: w_crc7 = 7'h7F;
    endcase
  end
`endif

  always_comb begin
    case (r_cnt[2:0])
      3'd0:    w_frame_byte = {2'b01, r_cmd};
      3'd1:    w_frame_byte = r_arg[31:24];
      3'd2:    w_frame_byte = r_arg[23:16];
      3'd3:    w_frame_byte = r_arg[15:8];
      3'd4:    w_frame_byte = r_arg[7:0];
      default: w_frame_byte = {w_crc7, 1'b1};
    endcase
  end

  // The engine raises busy one clock after wr, so the first WAIT cycle never completes a byte.
  assign w_byte_done = r_wait && !r_first && !i_spi_busy;
  assign w_poll_hit  = !i_spi_rx[7];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_spi_wr    = (r_state != S_IDLE) && !r_wait && !i_spi_busy;
    case (r_state)
      S_IDLE: begin
        if (i_start)                   w_state_nxt = S_PRE;
        else if (i_rd_byte && !r_cs_n) w_state_nxt = S_RD;
        else if (i_release && !r_cs_n) w_state_nxt = S_POST;
      end
      S_PRE:   if (w_byte_done) w_state_nxt = S_FRAME;
      S_FRAME: if (w_byte_done && r_cnt == 8'd5) w_state_nxt = S_POLL;
      S_POLL: begin
        if (w_byte_done) begin
          if (w_poll_hit)              w_state_nxt = r_keep ? S_IDLE : S_POST;
          else if (r_cnt == POLL_LAST) w_state_nxt = S_POST;
        end
      end
      S_RD:    if (w_byte_done) w_state_nxt = S_IDLE;
      S_POST:  if (w_byte_done && r_cnt == POST_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_wait    <= 1'b0;
      r_first   <= 1'b0;
      r_cnt     <= '0;
      r_r1      <= 8'hFF;
      r_rx      <= 8'hFF;
      r_timeout <= 1'b0;
      r_cs_n    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

      if (w_spi_wr) begin
        r_wait  <= 1'b1;
        r_first <= 1'b1;
      end else if (r_wait) begin
        if (r_first)          r_first <= 1'b0;
        else if (!i_spi_busy) r_wait  <= 1'b0;
      end

      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_byte_done)       r_cnt <= r_cnt + 8'd1;

      if (r_state == S_IDLE && i_start) r_timeout <= 1'b0;
      if (w_state_nxt == S_PRE)         r_cs_n    <= 1'b0;
      if (w_state_nxt == S_POST)        r_cs_n    <= 1'b1;

      if (r_state == S_POLL && w_byte_done) begin
        if (w_poll_hit) begin
          r_r1 <= i_spi_rx;
        end else if (r_cnt == POLL_LAST) begin
          r_r1      <= 8'hFF;
          r_timeout <= 1'b1;
        end
      end

      if (r_state == S_RD && w_byte_done) r_rx <= i_spi_rx;
    end
  end

  // Command fields are only read after a start has loaded them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && i_start) begin
      r_cmd  <= i_cmd;
      r_arg  <= i_arg;
      r_keep <= i_keep_cs;
    end
  end

  assign o_ready   = (r_state == S_IDLE);
  assign o_done    = r_done;
  assign o_r1      = r_r1;
  assign o_rx_byte = r_rx;
  assign o_timeout = r_timeout;
  assign o_cs_n    = r_cs_n;
  assign o_spi_wr  = w_spi_wr;
  assign o_spi_tx  = (r_state == S_FRAME) ? w_frame_byte : 8'hFF;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Self-checking bench for sd_cmd_seq: table of command vectors plus hand sequences for reads, release and reset.
// A small SPI engine model raises busy one clock after wr and returns queued response bytes.
module tb_sd_cmd_seq;

  localparam int POLL_MAX   = 8;
  localparam int POST_BYTES = 1;
  localparam int BUSY_LEN   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_keep_cs, i_rd_byte, i_release;
  logic [5:0]  i_cmd;
  logic [31:0] i_arg;
  logic        o_ready, o_done, o_timeout, o_cs_n, o_spi_wr;
  logic [7:0]  o_r1, o_rx_byte, o_spi_tx;
  logic [7:0]  i_spi_rx   = 8'hFF;
  logic        i_spi_busy = 1'b0;

  always #5 clk = ~clk;

  sd_cmd_seq #(.POLL_MAX(POLL_MAX), .POST_BYTES(POST_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_start(i_start), .i_cmd(i_cmd), .i_arg(i_arg), .i_keep_cs(i_keep_cs),
    .i_rd_byte(i_rd_byte), .i_release(i_release),
    .o_ready(o_ready), .o_done(o_done), .o_r1(o_r1), .o_rx_byte(o_rx_byte),
    .o_timeout(o_timeout), .o_cs_n(o_cs_n),
    .o_spi_wr(o_spi_wr), .o_spi_tx(o_spi_tx), .i_spi_rx(i_spi_rx), .i_spi_busy(i_spi_busy)
  );

  // SPI engine model: no reset, busy rises the clock after wr, response appears as busy falls.
  logic [7:0] resp_q[$];
  logic [7:0] tx_log[$];
  logic       cs_log[$];
  logic       armed   = 1'b0;
  int         bcnt    = 0;
  logic [7:0] rx_hold = 8'hFF;

  always @(posedge clk) begin
    if (o_spi_wr) begin
      tx_log.push_back(o_spi_tx);
      cs_log.push_back(o_cs_n);
      if (resp_q.size() > 0) rx_hold <= resp_q.pop_front();
      else                   rx_hold <= 8'hFF;
      armed <= 1'b1;
    end
    if (armed) begin
      i_spi_busy <= 1'b1;
      bcnt       <= BUSY_LEN;
      armed      <= 1'b0;
    end else if (i_spi_busy) begin
      if (bcnt == 1) begin
        i_spi_busy <= 1'b0;
        i_spi_rx   <= rx_hold;
      end
      bcnt <= bcnt - 1;
    end
  end

  int wr_busy_viol = 0;
  int done_cnt     = 0;
  always @(negedge clk) begin
    if (o_spi_wr && i_spi_busy) wr_busy_viol++;
    if (o_done) done_cnt++;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic        keep;
    int          ans;       // poll index that answers (1-based), 0 = never answers
    logic [7:0]  ans_val;
    logic [7:0]  crc_byte;
    logic        extra_rd;  // rd_byte asserted together with start
    logic        mid_start; // second start pulsed while the command is running
  } vec_t;

  vec_t vecs[5];

  task automatic run_cmd(input vec_t v, input string tag);
    logic [7:0] exp_tx[$];
    logic       exp_cs[$];
    int         n, d0;
    bit         to, post, seen;
    to   = (v.ans == 0);
    n    = to ? POLL_MAX : v.ans;
    post = !(v.keep && !to);
    exp_tx.push_back(8'hFF);              exp_cs.push_back(1'b0);
    exp_tx.push_back({2'b01, v.cmd});     exp_cs.push_back(1'b0);
    exp_tx.push_back(v.arg[31:24]);       exp_cs.push_back(1'b0);
    exp_tx.push_back(v.arg[23:16]);       exp_cs.push_back(1'b0);
    exp_tx.push_back(v.arg[15:8]);        exp_cs.push_back(1'b0);
    exp_tx.push_back(v.arg[7:0]);         exp_cs.push_back(1'b0);
    exp_tx.push_back(v.crc_byte);         exp_cs.push_back(1'b0);
    for (int i = 0; i < n; i++) begin exp_tx.push_back(8'hFF); exp_cs.push_back(1'b0); end
    if (post) for (int i = 0; i < POST_BYTES; i++) begin exp_tx.push_back(8'hFF); exp_cs.push_back(1'b1); end

    resp_q.delete();
    for (int i = 0; i < 7; i++) resp_q.push_back(8'hFF);
    if (!to) begin
      for (int i = 1; i < v.ans; i++) resp_q.push_back(8'hFF);
      resp_q.push_back(v.ans_val);
    end
    tx_log.delete();
    cs_log.delete();
    d0 = done_cnt;

    @(negedge clk);
    i_start = 1'b1; i_cmd = v.cmd; i_arg = v.arg; i_keep_cs = v.keep; i_rd_byte = v.extra_rd;
    @(negedge clk);
    i_start = 1'b0; i_rd_byte = 1'b0; i_cmd = 6'h2A; i_arg = 32'hDEADBEEF; i_keep_cs = ~v.keep;
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (o_done) begin seen = 1'b1; break; end
      if (v.mid_start && c == 12) begin i_start = 1'b1; i_cmd = 6'd17; end
      else if (c == 13) i_start = 1'b0;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_ready_with_done"}, 32'(o_ready), 32'd1);
    repeat (8) @(negedge clk);
    check({tag, "_nbytes"}, 32'(tx_log.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i < tx_log.size()) begin
        check($sformatf("%s_tx%0d", tag, i), 32'(tx_log[i]), 32'(exp_tx[i]));
        check($sformatf("%s_cs%0d", tag, i), 32'(cs_log[i]), 32'(exp_cs[i]));
      end
    end
    check({tag, "_r1"}, 32'(o_r1), to ? 32'hFF : 32'(v.ans_val));
    check({tag, "_timeout"}, 32'(o_timeout), 32'(to));
    check({tag, "_cs_n_end"}, 32'(o_cs_n), 32'(post));
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic short_op(input bit is_rel, input logic [7:0] resp, input string tag);
    int d0;
    bit seen;
    resp_q.delete();
    resp_q.push_back(resp);
    tx_log.delete();
    cs_log.delete();
    d0 = done_cnt;
    @(negedge clk);
    i_rd_byte = !is_rel; i_release = is_rel;
    @(negedge clk);
    i_rd_byte = 1'b0; i_release = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (o_done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    repeat (4) @(negedge clk);
    check({tag, "_nbytes"}, 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) begin
      check({tag, "_tx"}, 32'(tx_log[0]), 32'hFF);
      check({tag, "_cs_at_wr"}, 32'(cs_log[0]), 32'(is_rel));
    end
    check({tag, "_cs_n_end"}, 32'(o_cs_n), 32'(is_rel));
    if (!is_rel) check({tag, "_rx_byte"}, 32'(o_rx_byte), 32'(resp));
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    logic [7:0] crc17, crc58;
    bit         found;
    int         d0;
`ifdef SD_CMD_CRC7_EN
    crc17 = 8'h55;
    crc58 = 8'hFD;
`else
    crc17 = 8'hFF;
    crc58 = 8'hFF;
`endif
    //          cmd    arg           keep  ans  val    crc      rd    mid
    vecs[0] = '{6'd0,  32'h0000_0000, 1'b0, 2,   8'h01, 8'h95,   1'b0, 1'b0};
    vecs[1] = '{6'd8,  32'h0000_01AA, 1'b1, 1,   8'h01, 8'h87,   1'b0, 1'b0};
    vecs[2] = '{6'd0,  32'h0000_0000, 1'b1, 3,   8'h7F, 8'h95,   1'b1, 1'b1};
    vecs[3] = '{6'd17, 32'h0000_0000, 1'b1, 0,   8'hFF, crc17,   1'b0, 1'b0};
    vecs[4] = '{6'd58, 32'h0000_0000, 1'b0, 8,   8'h00, crc58,   1'b0, 1'b0};

    rst_n = 1'b0;
    i_start = 1'b0; i_cmd = '0; i_arg = '0; i_keep_cs = 1'b0; i_rd_byte = 1'b0; i_release = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",   32'(o_ready),   32'd1);
    check("rst_done",    32'(o_done),    32'd0);
    check("rst_r1",      32'(o_r1),      32'hFF);
    check("rst_rx_byte", 32'(o_rx_byte), 32'hFF);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    check("rst_cs_n",    32'(o_cs_n),    32'd1);
    check("rst_spi_wr",  32'(o_spi_wr),  32'd0);
    check("rst_spi_tx",  32'(o_spi_tx),  32'hFF);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_cmd(vecs[i], $sformatf("v%0d", i));

    // CMD8 held open, four trailing reads of the R7 payload, then release.
    run_cmd(vecs[1], "cmd8b");
    short_op(1'b0, 8'h00, "rd0");
    short_op(1'b0, 8'h00, "rd1");
    short_op(1'b0, 8'h01, "rd2");
    short_op(1'b0, 8'hAA, "rd3");
    short_op(1'b1, 8'hFF, "rel");

    // rd_byte / release with CS already high must be ignored.
    tx_log.delete();
    d0 = done_cnt;
    @(negedge clk);
    i_rd_byte = 1'b1; i_release = 1'b1;
    @(negedge clk);
    i_rd_byte = 1'b0; i_release = 1'b0;
    repeat (12) @(negedge clk);
    check("ign_nbytes", 32'(tx_log.size()), 32'd0);
    check("ign_done",   32'(done_cnt - d0), 32'd0);
    check("ign_ready",  32'(o_ready), 32'd1);

    // Reset while FRAME byte 3 is in flight in the engine.
    resp_q.delete();
    tx_log.delete();
    cs_log.delete();
    @(negedge clk);
    i_start = 1'b1; i_cmd = 6'd0; i_arg = 32'h0; i_keep_cs = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (tx_log.size() >= 5 && i_spi_busy) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("rst_mid_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_cs_n",    32'(o_cs_n),     32'd1);
    check("rst_mid_ready",   32'(o_ready),    32'd1);
    check("rst_mid_r1",      32'(o_r1),       32'hFF);
    check("rst_mid_rx_byte", 32'(o_rx_byte),  32'hFF);
    check("rst_mid_busy",    32'(i_spi_busy), 32'd1);
    rst_n = 1'b1;
    run_cmd(vecs[0], "post_rst");

    check("no_wr_while_busy", 32'(wr_busy_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
